// File: rtl/mux_sel_ctrl_pkg.sv
// Shared types and widths for the project-mux select controller.
package mux_sel_ctrl_pkg;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    SWITCH  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Request captured at acceptance; change=0 means re-reset only.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              change;
  } sel_req_t;
endpackage

// File: rtl/mux_sel_timer.sv
// Loadable down-counter shared by all phases; done marks the last cycle of a phase.
module mux_sel_timer
  import mux_sel_ctrl_pkg::*;
#(
  parameter int unsigned RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  // Saturates at zero so an idle controller never wraps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= CNT_W'(RST_VAL);
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign done = (cnt == CNT_W'(1));
endmodule

// File: rtl/mux_sel_ctrl.sv
// Sequences a project-mux address change: hold reset + isolate, switch, then release reset.
module mux_sel_ctrl
  import mux_sel_ctrl_pkg::*;
#(
  parameter int unsigned DEFAULT_ADDR = 0,
  parameter int unsigned PRE_CYCLES   = 4,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned POST_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_valid,
  input  logic [ADDR_W-1:0] sel_addr,
  output logic              sel_ready,
  input  logic              ext_rst_n,
  output logic [ADDR_W-1:0] addr,
  output logic              proj_rst_n,
  output logic              iso,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] DEF_A  = ADDR_W'(DEFAULT_ADDR);
  localparam logic [CNT_W-1:0]  PRE_C  = CNT_W'(PRE_CYCLES);
  localparam logic [CNT_W-1:0]  GRD_C  = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0]  POST_C = CNT_W'(POST_CYCLES);

  state_e           state, state_nxt;
  sel_req_t         req_q;
  logic             accept;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  assign accept = sel_valid && (state == IDLE);

  mux_sel_timer #(.RST_VAL(POST_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = POST_C;
    case (state)
      IDLE: if (sel_valid) begin
        state_nxt = DRAIN;
        tmr_load  = 1'b1;
        tmr_val   = PRE_C;
      end
      DRAIN: if (tmr_done) begin
        tmr_load = 1'b1;
        if (req_q.change) begin
          state_nxt = SWITCH;
          tmr_val   = GRD_C;
        end else begin
          state_nxt = RELEASE;
          tmr_val   = POST_C;
        end
      end
      SWITCH: if (tmr_done) begin
        state_nxt = RELEASE;
        tmr_load  = 1'b1;
        tmr_val   = POST_C;
      end
      RELEASE: if (tmr_done) state_nxt = IDLE;
      default: state_nxt = RELEASE;
    endcase
  end

  // Outputs are flopped from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RELEASE;
      req_q      <= '{addr: DEF_A, change: 1'b0};
      addr       <= DEF_A;
      proj_rst_n <= 1'b0;
      iso        <= 1'b0;
      busy       <= 1'b1;
      sel_ready  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) req_q <= '{addr: sel_addr, change: (sel_addr != addr)};
      if (state == DRAIN && state_nxt == SWITCH) addr <= req_q.addr;
      proj_rst_n <= (state_nxt == IDLE) && ext_rst_n;
      iso        <= (state_nxt == DRAIN) || (state_nxt == SWITCH);
      busy       <= (state_nxt != IDLE);
      sel_ready  <= (state_nxt == IDLE);
    end
  end
endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Randomized bench with a phase-arithmetic reference model and a per-sequence scoreboard.
module tb_mux_sel_ctrl;
  localparam int PRE = 4, GRD = 2, POST = 8, DEF = 0;

  logic       clk = 1'b0, rst = 1'b0, sel_valid = 1'b0, ext_rst_n = 1'b1;
  logic [4:0] sel_addr = '0;
  logic       sel_ready, proj_rst_n, iso, busy;
  logic [4:0] addr;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mux_sel_ctrl #(
    .DEFAULT_ADDR(DEF), .PRE_CYCLES(PRE), .GUARD_CYCLES(GRD), .POST_CYCLES(POST)
  ) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_addr(sel_addr),
    .sel_ready(sel_ready), .ext_rst_n(ext_rst_n), .addr(addr),
    .proj_rst_n(proj_rst_n), .iso(iso), .busy(busy)
  );

  typedef struct { int fin_addr; int busy_len; int iso_len; } exp_t;
  exp_t sb_q[$];

  // Model: cycles left busy, position inside the sequence, and where iso/addr events fall.
  int         m_left = POST, m_pos = 0, m_iso_len = 0, m_sw_at = -1;
  logic [4:0] m_addr = 5'(DEF), m_tgt = 5'(DEF);
  logic       m_extq = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    bit chg;
    int tot;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_left = POST; m_pos = 0; m_iso_len = 0; m_sw_at = -1;
        m_addr = 5'(DEF); m_tgt = 5'(DEF); m_extq = 1'b0;
        sb_q.delete();
      end else if (m_left == 0) begin
        m_extq = ext_rst_n;
        if (sel_valid) begin
          chg       = (sel_addr != m_addr);
          tot       = chg ? PRE + GRD + POST : PRE + POST;
          m_left    = tot;
          m_pos     = 0;
          m_iso_len = chg ? PRE + GRD : PRE;
          m_sw_at   = chg ? PRE : -1;
          m_tgt     = sel_addr;
          sb_q.push_back('{fin_addr: int'(chg ? sel_addr : m_addr), busy_len: tot, iso_len: m_iso_len});
        end
      end else begin
        m_extq = ext_rst_n;
        if (m_pos + 1 == m_sw_at) m_addr = m_tgt;
        m_pos++;
        m_left--;
      end
    end
  end

  initial begin
    logic prev_busy;
    bit   track;
    int   c_busy, c_iso;
    exp_t e;
    prev_busy = 1'b1; track = 0; c_busy = 0; c_iso = 0;
    #2;
    forever begin
      @(negedge clk);
      chk("addr", addr, m_addr);
      chk("busy", busy, m_left != 0);
      chk("sel_ready", sel_ready, m_left == 0);
      chk("iso", iso, (m_left != 0) && (m_pos < m_iso_len));
      chk("proj_rst_n", proj_rst_n, (m_left == 0) ? m_extq : 1'b0);
      if (rst) track = 0;
      else if (busy && !prev_busy) begin track = 1; c_busy = 0; c_iso = 0; end
      if (busy && track) begin
        c_busy++;
        if (iso) c_iso++;
      end
      if (!busy && prev_busy && track) begin
        track = 0;
        if (sb_q.size() == 0) chk("sb_unexpected_seq", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("sb_busy_len", c_busy, e.busy_len);
          chk("sb_iso_len", c_iso, e.iso_len);
          chk("sb_final_addr", addr, e.fin_addr);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic request(input logic [4:0] a);
    sel_valid = 1'b1; sel_addr = a;
    step(1);
    sel_valid = 1'b0; sel_addr = 5'($urandom_range(31));
  endtask

  initial begin
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(12);
    request(5'd5);                 // change 0 -> 5
    step(18);
    request(5'd5);                 // same address: re-reset only
    step(16);
    sel_valid = 1'b1; sel_addr = 5'd3;
    step(1);
    sel_addr = 5'd9;               // held during busy, must be ignored
    step(PRE + GRD + POST - 2);
    sel_valid = 1'b0;
    step(4);
    request(5'd7);                 // abort during SWITCH
    step(PRE);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(12);
    repeat (6) begin ext_rst_n = ~ext_rst_n; step(1); end
    ext_rst_n = 1'b1;
    step(2);
    request(5'd12);
    repeat (PRE + GRD + POST) begin ext_rst_n = 1'($urandom_range(1)); step(1); end
    ext_rst_n = 1'b1;
    step(4);
    repeat (400) begin
      sel_valid = ($urandom_range(3) == 0);
      sel_addr  = ($urandom_range(2) == 0) ? m_addr : 5'($urandom_range(31));
      ext_rst_n = ($urandom_range(7) != 0);
      rst       = ($urandom_range(149) == 0);
      step(1);
    end
    rst = 1'b0; sel_valid = 1'b0; ext_rst_n = 1'b1;
    step(30);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
